// File: rtl/cla_seq_adder_if.sv
// Operand/result bundle for the multi-cycle CLA adder/subtractor.
// The master issues start with operands; the slave reports busy/done and results.
interface cla_seq_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             C0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, sub, X, Y, C0,
      input  busy, done, sum, carry_out, overflow
   );

   modport slave (
      input  start, sub, X, Y, C0,
      output busy, done, sum, carry_out, overflow
   );
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor: one CHUNK-bit slice per clock,
// two-level lookahead inside the slice, carry registered between slices.
module cla_seq_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input logic            clk,
   input logic            rst_n,
   cla_seq_adder_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int NGRP   = CHUNK / 4;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((WIDTH % CHUNK) != 0 || (CHUNK % 4) != 0 || CHUNK < 4) begin : g_bad_params
      $error("cla_seq_adder: WIDTH must be a multiple of CHUNK, CHUNK a multiple of 4");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             co_q, co_d;
   logic             ov_q, ov_d;

   logic [31:0]      base;
   logic [CHUNK-1:0] a_s, b_s, slice_sum;
   logic [WIDTH-1:0] slice_mask;
   logic [NGRP-1:0]  grp_g, grp_p;
   logic [NGRP:0]    grp_c;
   logic             msb_cin;
   logic             last;

   // Sum-of-products carry into group n, flattened rather than rippled group to group.
   function automatic logic group_carry(input logic [NGRP-1:0] g, input logic [NGRP-1:0] p,
                                        input logic cin, input int n);
      logic res, term;
      term = cin;
      for (int k = 0; k < n; k++) term = term & p[k];
      res = term;
      for (int i = 0; i < n; i++) begin
         term = g[i];
         for (int k = i + 1; k < n; k++) term = term & p[k];
         res = res | term;
      end
      return res;
   endfunction

   assign base       = 32'(idx_q) * 32'(CHUNK);
   assign a_s        = CHUNK'(x_q >> base);
   assign b_s        = CHUNK'(y_q >> base);
   assign slice_mask = WIDTH'({CHUNK{1'b1}}) << base;
   assign last       = (idx_q == IDXW'(NCHUNK - 1));

   genvar gi;
   for (gi = 0; gi < NGRP; gi++) begin : g_grp
      logic [3:0] g, p;
      logic [3:0] c;
      assign g    = a_s[gi*4 +: 4] & b_s[gi*4 +: 4];
      assign p    = a_s[gi*4 +: 4] ^ b_s[gi*4 +: 4];
      assign c[0] = grp_c[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      assign grp_g[gi] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      assign grp_p[gi] = &p;
      assign slice_sum[gi*4 +: 4] = p ^ c;
      if (gi == NGRP - 1) begin : g_msb
         assign msb_cin = c[3];
      end
   end

   for (gi = 0; gi <= NGRP; gi++) begin : g_la
      assign grp_c[gi] = group_carry(grp_g, grp_p, carry_q, gi);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      co_d    = co_q;
      ov_d    = ov_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               // Subtraction is X + ~Y + 1, so the inverted operand and forced carry are latched here.
               state_d = S_RUN;
               x_d     = bus.X;
               y_d     = bus.sub ? ~bus.Y : bus.Y;
               carry_d = bus.sub ? 1'b1 : bus.C0;
               idx_d   = '0;
            end
         end
         S_RUN: begin
            sum_d   = (sum_q & ~slice_mask) | (WIDTH'(slice_sum) << base);
            carry_d = grp_c[NGRP];
            idx_d   = idx_q + 1'b1;
            if (last) begin
               state_d = S_DONE;
               idx_d   = '0;
               co_d    = grp_c[NGRP];
               ov_d    = msb_cin ^ grp_c[NGRP];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy      = (state_q == S_RUN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.sum       = sum_q;
   assign bus.carry_out = co_q;
   assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: three instances (8/4, 32/8, 32/32) driven through one
// selectable stimulus path and checked against an integer-arithmetic model.
module tb_cla_seq_adder;
   logic        clk;
   logic        rst_n;
   int          sel;
   logic        t_start, t_sub, t_c0;
   logic [31:0] t_x, t_y;
   logic        o_busy, o_done, o_co, o_ov;
   logic [31:0] o_sum;
   int          n_checks;
   int          n_fail;

   cla_seq_adder_if #(.WIDTH(8))  b8 ();
   cla_seq_adder_if #(.WIDTH(32)) b32 ();
   cla_seq_adder_if #(.WIDTH(32)) b32w ();

   cla_seq_adder #(.WIDTH(8),  .CHUNK(4))  u_dut8   (.clk(clk), .rst_n(rst_n), .bus(b8));
   cla_seq_adder #(.WIDTH(32), .CHUNK(8))  u_dut32  (.clk(clk), .rst_n(rst_n), .bus(b32));
   cla_seq_adder #(.WIDTH(32), .CHUNK(32)) u_dut32w (.clk(clk), .rst_n(rst_n), .bus(b32w));

   assign b8.start   = t_start && (sel == 0);
   assign b32.start  = t_start && (sel == 1);
   assign b32w.start = t_start && (sel == 2);
   assign b8.sub     = t_sub;
   assign b32.sub    = t_sub;
   assign b32w.sub   = t_sub;
   assign b8.C0      = t_c0;
   assign b32.C0     = t_c0;
   assign b32w.C0    = t_c0;
   assign b8.X       = t_x[7:0];
   assign b8.Y       = t_y[7:0];
   assign b32.X      = t_x;
   assign b32.Y      = t_y;
   assign b32w.X     = t_x;
   assign b32w.Y     = t_y;

   assign o_busy = (sel == 0) ? b8.busy      : (sel == 1) ? b32.busy      : b32w.busy;
   assign o_done = (sel == 0) ? b8.done      : (sel == 1) ? b32.done      : b32w.done;
   assign o_co   = (sel == 0) ? b8.carry_out : (sel == 1) ? b32.carry_out : b32w.carry_out;
   assign o_ov   = (sel == 0) ? b8.overflow  : (sel == 1) ? b32.overflow  : b32w.overflow;
   assign o_sum  = (sel == 0) ? {24'd0, b8.sum} : (sel == 1) ? b32.sum : b32w.sum;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       sub;
      logic [7:0] x;
      logic [7:0] y;
      logic       c0;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations.
   function automatic void model(input int w, input logic s, input logic [31:0] x,
                                 input logic [31:0] y, input logic c, output logic [31:0] es,
                                 output logic eco, output logic eov);
      longint m, half, ux, uy, sx, sy, r, sr;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ux   = longint'({32'd0, x}) & m;
      uy   = longint'({32'd0, y}) & m;
      sx   = (ux >= half) ? ux - 2 * half : ux;
      sy   = (uy >= half) ? uy - 2 * half : uy;
      if (s) begin
         r   = ux - uy;
         eco = (ux >= uy);
         sr  = sx - sy;
      end else begin
         r   = ux + uy + longint'(c);
         eco = (r > m);
         sr  = sx + sy + longint'(c);
      end
      es  = 32'(r & m);
      eov = (sr >= half) || (sr < -half);
   endfunction

   // Called at a negedge; returns at the negedge where done is high.
   task automatic do_op(input int s_sel, input logic s_sub, input logic [31:0] x,
                        input logic [31:0] y, input logic c0, output logic [31:0] gs,
                        output logic gco, output logic gov);
      int          w, n, lat;
      bit          busy_ok;
      logic [31:0] es;
      logic        eco, eov;
      w = (s_sel == 0) ? 8 : 32;
      n = (s_sel == 0) ? 2 : (s_sel == 1) ? 4 : 1;
      model(w, s_sub, x, y, c0, es, eco, eov);
      sel     = s_sel;
      t_sub   = s_sub;
      t_x     = x;
      t_y     = y;
      t_c0    = c0;
      t_start = 1'b1;
      @(posedge clk);
      #1;
      t_start = 1'b0;
      t_x     = $urandom;
      t_y     = $urandom;
      t_sub   = 1'($urandom_range(0, 1));
      t_c0    = 1'($urandom_range(0, 1));
      lat     = 0;
      busy_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_done) break;
         if (!o_busy) busy_ok = 1'b0;
         @(posedge clk);
         lat++;
      end
      gs  = o_sum;
      gco = o_co;
      gov = o_ov;
      $display("op dut=%0d sub=%0b x=%h y=%h c0=%0b -> sum=%h co=%0b ov=%0b after %0d cycles",
               s_sel, s_sub, x, y, c0, gs, gco, gov, lat);
      chk("latency", 64'(lat), 64'(n));
      chk("busy_during_run", {63'd0, busy_ok && !o_busy}, 64'd1);
      chk("sum", {32'd0, gs}, {32'd0, es});
      chk("carry_out", {63'd0, gco}, {63'd0, eco});
      chk("overflow", {63'd0, gov}, {63'd0, eov});
   endtask

   initial begin
      logic [31:0] gs, acc, rx, ry;
      logic        gco, gov, rs, rc;
      int          dones, overlap, rsel;

      n_checks = 0;
      n_fail   = 0;
      sel      = 0;
      t_start  = 1'b0;
      t_sub    = 1'b0;
      t_c0     = 1'b0;
      t_x      = '0;
      t_y      = '0;
      rst_n    = 1'b0;

      tbl[0] = '{1'b0, 8'd1,   8'd2,   1'b0, 8'd3,   1'b0, 1'b0};
      tbl[1] = '{1'b0, 8'd7,   8'd7,   1'b1, 8'd15,  1'b0, 1'b0};
      tbl[2] = '{1'b0, 8'd127, 8'd128, 1'b0, 8'd255, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1};
      tbl[4] = '{1'b0, 8'd64,  8'd64,  1'b0, 8'd128, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 8'd5,   8'd7,   1'b0, 8'd254, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 8'd7,   8'd5,   1'b0, 8'd2,   1'b1, 1'b0};
      tbl[7] = '{1'b1, 8'd128, 8'd1,   1'b0, 8'd127, 1'b1, 1'b1};
      tbl[8] = '{1'b0, 8'd255, 8'd1,   1'b1, 8'd1,   1'b1, 1'b0};
      tbl[9] = '{1'b1, 8'd0,   8'd0,   1'b1, 8'd0,   1'b1, 1'b0};

      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk("reset_busy", {63'd0, o_busy}, 64'd0);
         chk("reset_done", {63'd0, o_done}, 64'd0);
         chk("reset_sum", {32'd0, o_sum}, 64'd0);
         chk("reset_co", {63'd0, o_co}, 64'd0);
         chk("reset_ov", {63'd0, o_ov}, 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         do_op(0, tbl[i].sub, {24'd0, tbl[i].x}, {24'd0, tbl[i].y}, tbl[i].c0, gs, gco, gov);
         chk("tbl_sum", {32'd0, gs}, {56'd0, tbl[i].s});
         chk("tbl_co", {63'd0, gco}, {63'd0, tbl[i].co});
         chk("tbl_ov", {63'd0, gov}, {63'd0, tbl[i].ov});
      end

      // start held high for 10 edges on the 8/4 instance: accepted every third edge.
      @(negedge clk);
      sel     = 0;
      t_sub   = 1'b0;
      t_c0    = 1'b0;
      t_x     = 32'd3;
      t_y     = 32'd4;
      t_start = 1'b1;
      dones   = 0;
      overlap = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == 9) t_start = 1'b0;
         if (o_busy && o_done) overlap++;
         if (o_done) begin
            dones++;
            chk("held_start_sum", {32'd0, o_sum}, 64'd7);
         end
      end
      $display("held start: %0d done pulses, %0d busy/done overlaps", dones, overlap);
      chk("held_start_dones", 64'(dones), 64'd4);
      chk("held_start_overlap", 64'(overlap), 64'd0);

      // Asynchronous reset in the second RUN cycle aborts the op.
      do_op(0, 1'b0, 32'h90, 32'h90, 1'b0, gs, gco, gov);
      @(negedge clk);
      t_x     = 32'd1;
      t_y     = 32'd1;
      t_start = 1'b1;
      @(posedge clk);
      #1;
      t_start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      $display("reset mid-run: busy=%0b done=%0b sum=%h co=%0b ov=%0b", o_busy, o_done, o_sum, o_co, o_ov);
      chk("midrst_busy", {63'd0, o_busy}, 64'd0);
      chk("midrst_done", {63'd0, o_done}, 64'd0);
      chk("midrst_sum", {32'd0, o_sum}, 64'd0);
      chk("midrst_co", {63'd0, o_co}, 64'd0);
      chk("midrst_ov", {63'd0, o_ov}, 64'd0);
      dones = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (o_done || o_busy) dones++;
      end
      chk("midrst_no_done", 64'(dones), 64'd0);
      do_op(0, 1'b1, 32'd9, 32'd4, 1'b0, gs, gco, gov);

      // Accumulate on the 32/8 instance: Y takes the previous sum each op.
      acc = 32'd0;
      for (int i = 0; i < 200; i++) begin
         do_op(1, 1'b0, 32'd1, acc, 1'b0, gs, gco, gov);
         acc = gs;
      end
      chk("accum_sum", {32'd0, acc}, 64'd200);
      chk("accum_co", {63'd0, gco}, 64'd0);

      for (int i = 0; i < 1000; i++) begin
         rsel = i % 3;
         rs   = 1'($urandom_range(0, 1));
         rc   = 1'($urandom_range(0, 1));
         rx   = $urandom;
         ry   = $urandom;
         case ($urandom_range(0, 7))
            0: rx = 32'hFFFF_FFFF;
            1: ry = 32'h8000_0000;
            2: begin rx = 32'h0000_0080; ry = 32'h0000_0080; end
            3: ry = rx;
            default: ;
         endcase
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         do_op(rsel, rs, rx, ry, rc, gs, gco, gov);
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Parametrised multi-cycle carry-lookahead adder/subtractor; successor to the team's fixed 8-bit combinational CLA.
- Processes a WIDTH-bit operand pair in CHUNK-bit slices, one slice per clock. Each slice uses full lookahead internally; the carry is registered between slices.
- Start/busy/done handshake lets datapath controllers trade latency for a short critical path at large WIDTH.
- Adds subtract mode and a signed-overflow flag.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock; must be a multiple of 4 (4-bit lookahead groups inside each slice, group carries via second-level lookahead).
- NCHUNK, WIDTH/CHUNK, derived local parameter, not overridable; cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = X+Y+C0; 1 = X-Y (X + ~Y + 1, C0 ignored).
- X  input  WIDTH  operand A; latched on accepted start.
- Y  input  WIDTH  operand B; latched on accepted start.
- C0  input  1  carry in (add mode only); latched on accepted start.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse when results are valid.
- sum  output  WIDTH  result, registered.
- carry_out  output  1  carry from MSB; in sub mode 1 = no borrow (X >= Y unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, async): state IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0; operand, carry and slice-index registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k -> RUN. Latch X, Y (stored as ~Y if sub), carry = sub ? 1 : C0, idx=0. busy=1 from edge k.
  - RUN: each edge computes slice idx, bits [idx*CHUNK +: CHUNK], from latched operands and the registered carry. Writes that slice of sum, updates carry, idx++.
  - RUN -> DONE: at the edge processing idx=NCHUNK-1, i.e. edge k+NCHUNK. At that edge carry_out and overflow are written, busy falls and done rises.
  - DONE lasts exactly one cycle. start=1 here is accepted as in IDLE (back-to-back; busy stays low for that cycle only, then rises at the same edge done falls). Otherwise -> IDLE.
- Latency: done high during cycle k+NCHUNK; throughput one op per NCHUNK+1 cycles.
- start while busy is ignored; X/Y/C0/sub changes during RUN have no effect (operands latched).
- sum slices update progressively during RUN; sum is defined only when done=1. sum/carry_out/overflow hold their last values in IDLE until the next accepted start completes.
- Arithmetic modulo 2^WIDTH. Overflow is computed from the carry into bit WIDTH-1 of the final slice.
- NCHUNK=1 legal: single-cycle RUN, done at edge k+1.

Test Plan:
- WIDTH=8, CHUNK=4: X=1, Y=2, C0=0 -> done exactly 2 cycles after start, sum=3, carry_out=0, overflow=0. Then X=7, Y=7, C0=1 -> sum=15.
- WIDTH=8: X=127, Y=128 -> sum=255, co=0, ov=0. X=128, Y=128 -> sum=0, co=1, ov=1. X=64, Y=64 -> sum=128, co=0, ov=1.
- Subtract, WIDTH=8: X=5, Y=7, sub=1 -> sum=254, co=0, ov=0. X=7, Y=5 -> sum=2, co=1. X=128, Y=1 -> sum=127, ov=1.
- Handshake: start held high for 10 cycles -> ops accepted only in IDLE/DONE, one done pulse per op, busy never overlaps done. Operands changed mid-RUN -> result matches latched values.
- Reset: rst_n low in the 2nd RUN cycle -> all outputs 0 immediately (async), no done pulse; next start works normally.
- WIDTH=32, CHUNK=8 accumulate: X=1, Y=0, then 200 back-to-back ops with Y fed from the previous sum at each done -> final sum=200, co=0. Random 1000 ops vs a behavioural + / - model, including CHUNK=WIDTH.
